// File: rtl/arcade_input_conditioner.sv
// Synchronises, debounces and inverts arcade player/start controls; turns coin rising edges
// into a saturating queue of fixed-width active-low coin pulses for the 8080 core.
module arcade_input_conditioner #(
    parameter logic [15:0] DEBOUNCE    = 16'd50000,
    parameter logic [19:0] COIN_PULSE  = 20'd400000,
    parameter logic [19:0] COIN_GAP    = 20'd400000,
    parameter logic [1:0]  MAX_PENDING = 2'd3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] coin_in,
    input  logic [1:0] start_in,
    input  logic [2:0] p1_in,
    input  logic [2:0] p2_in,
    output logic       coin_n,
    output logic       sel1_n,
    output logic       sel2_n,
    output logic       firea_n,
    output logic       lefta_n,
    output logic       righta_n,
    output logic       fireb_n,
    output logic       leftb_n,
    output logic       rightb_n,
    output logic [1:0] coin_pending,
    output logic       coin_dropped
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    // Bit map: [1:0] coin, [3:2] start, [6:4] p1 {fire,left,right}, [9:7] p2 {fire,left,right}
    logic [9:0]       raw;
    logic [9:0]       sync1_q, sync2_q;
    logic [9:0]       deb_q, deb_d;
    logic [9:0][15:0] cnt_q, cnt_d;
    logic [7:0]       ctl_n_q, ctl_n_d;
    logic [1:0]       coin_rise;
    logic [2:0]       ev_cnt, pend_sum;
    logic [1:0]       pending_q, pending_d;
    logic             dropped_q, dropped_d;
    logic             take;
    state_t           state_q, state_d;
    logic [19:0]      timer_q, timer_d;
    logic             coin_n_q;

    assign raw = {p2_in, p1_in, start_in, coin_in};

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 10; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= DEBOUNCE - 16'd1) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // A player pressing both directions at once gets neither.
    always_comb begin
        ctl_n_d[7] = ~deb_q[3];
        ctl_n_d[6] = ~deb_q[2];
        ctl_n_d[5] = ~deb_q[6];
        ctl_n_d[4] = ~(deb_q[5] & ~deb_q[4]);
        ctl_n_d[3] = ~(deb_q[4] & ~deb_q[5]);
        ctl_n_d[2] = ~deb_q[9];
        ctl_n_d[1] = ~(deb_q[8] & ~deb_q[7]);
        ctl_n_d[0] = ~(deb_q[7] & ~deb_q[8]);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != 2'd0) begin
                    state_d = PULSE;
                    timer_d = '0;
                    take    = 1'b1;
                end
            end
            PULSE: begin
                if (timer_q >= COIN_PULSE - 20'd1) begin
                    state_d = GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end
            GAP: begin
                if (timer_q >= COIN_GAP - 20'd1) begin
                    timer_d = '0;
                    if (pending_q != 2'd0) begin
                        state_d = PULSE;
                        take    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Events and the FSM's take net first; saturation only clips the result.
    always_comb begin
        coin_rise = deb_d[1:0] & ~deb_q[1:0];
        ev_cnt    = {2'b00, coin_rise[0]} + {2'b00, coin_rise[1]};
        pend_sum  = {1'b0, pending_q} + ev_cnt - {2'b00, take};
        pending_d = pend_sum[1:0];
        dropped_d = 1'b0;
        if (pend_sum > {1'b0, MAX_PENDING}) begin
            pending_d = MAX_PENDING;
            dropped_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            ctl_n_q   <= '1;
            pending_q <= '0;
            dropped_q <= 1'b0;
            state_q   <= IDLE;
            timer_q   <= '0;
            coin_n_q  <= 1'b1;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            ctl_n_q   <= ctl_n_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            coin_n_q  <= (state_q != PULSE);
        end
    end

    assign {sel2_n, sel1_n, firea_n, lefta_n, righta_n, fireb_n, leftb_n, rightb_n} = ctl_n_q;
    assign coin_n       = coin_n_q;
    assign coin_pending = pending_q;
    assign coin_dropped = dropped_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Bench for arcade_input_conditioner with short debounce/pulse parameters.
module tb_arcade_input_conditioner;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] coin_in  = '0;
    logic [1:0] start_in = '0;
    logic [2:0] p1_in    = '0;
    logic [2:0] p2_in    = '0;
    logic       coin_n, sel1_n, sel2_n, firea_n, lefta_n, righta_n, fireb_n, leftb_n, rightb_n;
    logic [1:0] coin_pending;
    logic       coin_dropped;

    always #5 clk_sys = ~clk_sys;

    arcade_input_conditioner #(
        .DEBOUNCE(16'd4), .COIN_PULSE(20'd8), .COIN_GAP(20'd4), .MAX_PENDING(2'd3)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .coin_in(coin_in), .start_in(start_in),
        .p1_in(p1_in), .p2_in(p2_in), .coin_n(coin_n), .sel1_n(sel1_n), .sel2_n(sel2_n),
        .firea_n(firea_n), .lefta_n(lefta_n), .righta_n(righta_n),
        .fireb_n(fireb_n), .leftb_n(leftb_n), .rightb_n(rightb_n),
        .coin_pending(coin_pending), .coin_dropped(coin_dropped)
    );

    // [11] dropped [10:9] pending [8] coin_n [7] sel2 [6] sel1 [5:3] A fire/left/right [2:0] B
    logic [11:0] outs;
    assign outs = {coin_dropped, coin_pending, coin_n, sel2_n, sel1_n, firea_n, lefta_n,
                   righta_n, fireb_n, leftb_n, rightb_n};
    localparam logic [11:0] IDLE_O = 12'h1FF;

    typedef struct {
        int          cyc;
        logic [11:0] mask;
        logic [11:0] val;
        string       name;
    } exp_t;

    typedef struct {
        string      name;
        logic [9:0] raw;
        int         hold;
        logic [7:0] act;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[13];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   nfall   = 0;
    int   ndrop   = 0;
    logic prev_coin_n = 1'b1;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_at(input int c, input logic [11:0] mask, input logic [11:0] val,
                             input string name);
        sb_q.push_back('{c, mask, val, name});
    endtask

    // Advance to the next falling edge, then retire every expectation due now.
    task automatic tick();
        @(negedge clk_sys);
        cyc++;
        if (prev_coin_n === 1'b1 && coin_n === 1'b0) nfall++;
        if (coin_dropped === 1'b1) ndrop++;
        prev_coin_n = coin_n;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc < cyc) begin
                check_int({sb_q[i].name, " stale"}, sb_q[i].cyc, cyc);
                sb_q.delete(i);
            end else if (sb_q[i].cyc == cyc) begin
                check(sb_q[i].name, outs & sb_q[i].mask, sb_q[i].val & sb_q[i].mask);
                sb_q.delete(i);
            end
        end
    endtask

    task automatic drive_raw(input logic [9:0] r);
        {p2_in, p1_in, start_in, coin_in} = r;
    endtask

    task automatic apply_vec(input vec_t v);
        int          c0;
        int          c1;
        logic [11:0] act_o;
        act_o = {4'h1, v.act};
        c0 = cyc;
        expect_at(c0 + 6, 12'hFFF, IDLE_O, {v.name, " +6"});
        expect_at(c0 + 7, 12'hFFF, act_o, {v.name, " +7"});
        drive_raw(v.raw);
        repeat (v.hold) tick();
        c1 = cyc;
        expect_at(c1 + 6, 12'hFFF, act_o, {v.name, " release +6"});
        expect_at(c1 + 7, 12'hFFF, IDLE_O, {v.name, " release +7"});
        drive_raw('0);
        repeat (12) tick();
    endtask

    // Reference coin_n: first low 8 cycles after the first sample, 8 low then 4 high per coin.
    task automatic expect_coin(input int c0, input int npulses, input int span, input string name);
        for (int k = c0 + 1; k <= c0 + span; k++) begin
            int r;
            r = k - (c0 + 8);
            if (r >= 0 && (r / 12) < npulses && (r % 12) < 8)
                expect_at(k, 12'h100, 12'h000, {name, " coin_n"});
            else
                expect_at(k, 12'h100, 12'h100, {name, " coin_n"});
        end
    endtask

    task automatic coin_test(input string name, input logic [1:0] bits, input int hold,
                             input int presses, input int npulses, input int ndrops,
                             input int span);
        int c0;
        int f0;
        int d0;
        c0 = cyc;
        f0 = nfall;
        d0 = ndrop;
        expect_coin(c0, npulses, span, name);
        for (int p = 0; p < presses; p++) begin
            coin_in = bits;
            repeat (hold) tick();
            coin_in = 2'b00;
            repeat (4) tick();
        end
        while (cyc < c0 + span + 2) tick();
        check_int({name, " pulse count"}, nfall - f0, npulses);
        check_int({name, " drop count"}, ndrop - d0, ndrops);
    endtask

    initial begin
        int c0;
        int c1;
        int f0;
        vecs[0]  = '{"p1 fire glitch",     10'h040, 3,  8'hFF};
        vecs[1]  = '{"p1 fire held",       10'h040, 10, 8'hDF};
        vecs[2]  = '{"p1 fire min width",  10'h040, 4,  8'hDF};
        vecs[3]  = '{"p1 left",            10'h020, 10, 8'hEF};
        vecs[4]  = '{"p1 right",           10'h010, 10, 8'hF7};
        vecs[5]  = '{"p1 opposing",        10'h030, 10, 8'hFF};
        vecs[6]  = '{"p1 fire+left",       10'h060, 10, 8'hCF};
        vecs[7]  = '{"p2 fire",            10'h200, 10, 8'hFB};
        vecs[8]  = '{"p2 left",            10'h100, 10, 8'hFD};
        vecs[9]  = '{"p2 opposing+fire",   10'h380, 10, 8'hFB};
        vecs[10] = '{"start one",          10'h004, 10, 8'hBF};
        vecs[11] = '{"start two",          10'h008, 10, 8'h7F};
        vecs[12] = '{"start glitch",       10'h00C, 2,  8'hFF};

        reset = 1'b1;
        drive_raw('0);
        repeat (3) begin
            tick();
            check("reset state", outs, IDLE_O);
        end
        reset = 1'b0;
        tick();
        check("after reset release", outs, IDLE_O);

        for (int i = 0; i < 13; i++) apply_vec(vecs[i]);

        // Player B left+right together, then right released.
        c0 = cyc;
        for (int k = 6; k <= 10; k++) expect_at(c0 + k, 12'hFFF, IDLE_O, "p2 both dirs held");
        p2_in = 3'b011;
        repeat (12) tick();
        c1 = cyc;
        p2_in = 3'b010;
        expect_at(c1 + 6, 12'h003, 12'h003, "p2 right drop +6");
        expect_at(c1 + 7, 12'h003, 12'h001, "p2 right drop +7");
        repeat (10) tick();
        p2_in = 3'b000;
        repeat (10) tick();
        check("p2 released", outs, IDLE_O);

        c0 = cyc;
        expect_at(c0 + 5, 12'h600, 12'h000, "single pending +5");
        expect_at(c0 + 6, 12'h600, 12'h200, "single pending +6");
        expect_at(c0 + 7, 12'h600, 12'h000, "single pending +7");
        coin_test("single coin", 2'b01, 10, 1, 1, 0, 30);

        c0 = cyc;
        expect_at(c0 + 6,  12'h600, 12'h400, "double pending +6");
        expect_at(c0 + 7,  12'h600, 12'h200, "double pending +7");
        expect_at(c0 + 18, 12'h600, 12'h200, "double pending +18");
        expect_at(c0 + 19, 12'h600, 12'h000, "double pending +19");
        coin_test("double coin", 2'b11, 10, 1, 2, 0, 40);

        c0 = cyc;
        expect_at(c0 + 6,  12'hE00, 12'h400, "sat pending +6");
        expect_at(c0 + 7,  12'hE00, 12'h200, "sat pending +7");
        expect_at(c0 + 14, 12'hE00, 12'h600, "sat pending +14");
        expect_at(c0 + 19, 12'hE00, 12'h400, "sat pending +19");
        expect_at(c0 + 21, 12'hE00, 12'h400, "sat pending +21");
        expect_at(c0 + 22, 12'hE00, 12'hE00, "sat drop +22");
        expect_at(c0 + 23, 12'hE00, 12'h600, "sat pending +23");
        expect_at(c0 + 30, 12'hE00, 12'h600, "sat pending +30");
        expect_at(c0 + 31, 12'hE00, 12'h400, "sat pending +31");
        expect_at(c0 + 43, 12'hE00, 12'h200, "sat pending +43");
        expect_at(c0 + 55, 12'hE00, 12'h000, "sat pending +55");
        coin_test("saturation", 2'b11, 4, 3, 5, 1, 72);

        // Asynchronous reset in the middle of a pulse with one coin still queued.
        c0 = cyc;
        coin_in = 2'b11;
        repeat (5) tick();
        coin_in = 2'b00;
        while (cyc < c0 + 11) tick();
        check("mid pulse before reset", outs & 12'h700, 12'h200);
        #2 reset = 1'b1;
        #1 check("async reset mid pulse", outs, IDLE_O);
        tick();
        reset = 1'b0;
        f0 = nfall;
        repeat (30) tick();
        check_int("queued coin discarded", nfall - f0, 0);
        check("idle after reset", outs, IDLE_O);

        check_int("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
